// File: rtl/iir_mac_sched.sv
// iir_mac_sched: control sequencer for a direct-form IIR filter built around
// one shared multiply-accumulate unit. Each accepted input sample is walked
// through the b (feed-forward) taps, then the a (feedback) taps. The
// scheduler then waits for the MAC pipeline to empty, and finally presents
// y[n] downstream with a valid/ready handshake.
module iir_mac_sched #(
  parameter int N_B     = 4,  // feed-forward taps, 1..8
  parameter int N_A     = 6,  // feedback taps, 1..8
  parameter int MAC_LAT = 2   // MAC pipeline depth, 0..7
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        hist_push,
  output logic        mac_clr,
  output logic        mac_en,
  output logic        coef_sel,
  output logic [2:0]  coef_idx,
  output logic [2:0]  tap_idx,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_hist_push,
  output logic        busy,
  output logic [15:0] sample_cnt
);

  // Last tap index in each bank, and the drain length loaded into the
  // down-counter once the final feedback product has been issued.
  localparam logic [2:0] B_LAST    = 3'(N_B - 1);
  localparam logic [2:0] A_LAST    = 3'(N_A - 1);
  localparam logic [2:0] DRAIN_LD  = 3'(MAC_LAT);
  localparam bit         NO_DRAIN  = (MAC_LAT == 0);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FIR   = 3'd1,
    S_IIR   = 3'd2,
    S_DRAIN = 3'd3,
    S_OUT   = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  k_q, k_d;          // tap index within the active bank
  logic [2:0]  drain_q, drain_d;  // remaining MAC pipeline flush cycles
  logic [15:0] cnt_q, cnt_d;      // completed output handshakes

  assign sample_cnt = cnt_q;

  // State, tap index, drain counter and sample counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      k_q     <= 3'd0;
      drain_q <= 3'd0;
      cnt_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      drain_q <= drain_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic and per-state control outputs. While rst_n is low,
  // state_q is already IDLE, so only the IDLE handshake terms need gating.
  // That gating keeps in_ready and hist_push low during reset.
  always_comb begin
    state_d       = state_q;
    k_d           = k_q;
    drain_d       = drain_q;
    cnt_d         = cnt_q;
    in_ready      = 1'b0;
    hist_push     = 1'b0;
    mac_clr       = 1'b0;
    mac_en        = 1'b0;
    coef_sel      = 1'b0;
    coef_idx      = 3'd0;
    tap_idx       = 3'd0;
    out_valid     = 1'b0;
    out_hist_push = 1'b0;
    busy          = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        in_ready = en & rst_n;
        if (in_ready && in_valid) begin
          hist_push = 1'b1;
          k_d       = 3'd0;
          state_d   = S_FIR;
        end
      end

      S_FIR: begin
        busy     = 1'b1;
        mac_en   = 1'b1;
        coef_idx = k_q;
        tap_idx  = k_q;
        // The first b product starts a fresh accumulation.
        mac_clr  = (k_q == 3'd0);
        if (k_q == B_LAST) begin
          k_d     = 3'd0;
          state_d = S_IIR;
        end else begin
          k_d = k_q + 3'd1;
        end
      end

      S_IIR: begin
        busy     = 1'b1;
        mac_en   = 1'b1;
        coef_sel = 1'b1;
        coef_idx = k_q;
        tap_idx  = k_q;
        if (k_q == A_LAST) begin
          k_d = 3'd0;
          if (NO_DRAIN) begin
            state_d = S_OUT;
          end else begin
            drain_d = DRAIN_LD;
            state_d = S_DRAIN;
          end
        end else begin
          k_d = k_q + 3'd1;
        end
      end

      S_DRAIN: begin
        busy = 1'b1;
        // Leave after exactly MAC_LAT cycles, once the last product has landed.
        if (drain_q <= 3'd1) begin
          drain_d = 3'd0;
          state_d = S_OUT;
        end else begin
          drain_d = drain_q - 3'd1;
        end
      end

      S_OUT: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          out_hist_push = 1'b1;
          cnt_d         = cnt_q + 16'd1;
          state_d       = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
        k_d     = 3'd0;
        drain_d = 3'd0;
      end
    endcase
  end

endmodule

// File: tb/tb_iir_mac_sched.sv
// Bench for iir_mac_sched. It drives a default instance and a minimal
// (1,1,0) instance from the same stimulus. A cycle-indexed schedule model
// checks both instances: each sample's timeline is derived from its
// position since acceptance.
module tb_iir_mac_sched;

  logic clk = 1'b0;
  logic rst_n, en, in_valid, out_ready;
  always #5 clk = ~clk;

  logic        ir_a, hp_a, clr_a, me_a, sel_a, ov_a, ohp_a, bz_a;
  logic [2:0]  ci_a, ti_a;
  logic [15:0] cnt_a;
  logic        ir_b, hp_b, clr_b, me_b, sel_b, ov_b, ohp_b, bz_b;
  logic [2:0]  ci_b, ti_b;
  logic [15:0] cnt_b;

  iir_mac_sched dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_ready(ir_a),
    .hist_push(hp_a), .mac_clr(clr_a), .mac_en(me_a), .coef_sel(sel_a),
    .coef_idx(ci_a), .tap_idx(ti_a), .out_valid(ov_a), .out_ready(out_ready),
    .out_hist_push(ohp_a), .busy(bz_a), .sample_cnt(cnt_a)
  );

  iir_mac_sched #(.N_B(1), .N_A(1), .MAC_LAT(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_ready(ir_b),
    .hist_push(hp_b), .mac_clr(clr_b), .mac_en(me_b), .coef_sel(sel_b),
    .coef_idx(ci_b), .tap_idx(ti_b), .out_valid(ov_b), .out_ready(out_ready),
    .out_hist_push(ohp_b), .busy(bz_b), .sample_cnt(cnt_b)
  );

  logic [13:0] pa, pb;
  assign pa = {ir_a, hp_a, clr_a, me_a, sel_a, ci_a, ti_a, ov_a, ohp_a, bz_a};
  assign pb = {ir_b, hp_b, clr_b, me_b, sel_b, ci_b, ti_b, ov_b, ohp_b, bz_b};

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int ma_t  = 0, mb_t = 0;          // cycles since accept, 0 = idle
  logic [15:0] ma_c = 0, mb_c = 0;  // expected completed samples
  int acc_q[$];                     // cycles at which dut_a accepted

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Expected outputs as a function of the position t within a sample.
  function automatic logic [13:0] exp_out(input int nb, input int na, input int ml,
                                          input int t, input logic r, input logic e,
                                          input logic iv, input logic ordy);
    logic ir, hp, clr, me, sel, ov, ohp, bz;
    int idx;
    {ir, hp, clr, me, sel, ov, ohp, bz} = '0;
    idx = 0;
    if (!r) return '0;
    if (t == 0) begin
      ir = e;
      hp = e & iv;
    end else begin
      bz = 1'b1;
      if (t <= nb) begin
        me = 1'b1; idx = t - 1; clr = (t == 1);
      end else if (t <= nb + na) begin
        me = 1'b1; sel = 1'b1; idx = t - nb - 1;
      end else if (t == nb + na + ml + 1) begin
        ov = 1'b1; ohp = ordy;
      end
    end
    return {ir, hp, clr, me, sel, idx[2:0], idx[2:0], ov, ohp, bz};
  endfunction

  function automatic int next_t(input int nb, input int na, input int ml, input int t,
                                input logic r, input logic e, input logic iv, input logic ordy);
    if (!r) return 0;
    if (t == 0) return (e && iv) ? 1 : 0;
    if (t == nb + na + ml + 1) return ordy ? 0 : t;
    return t + 1;
  endfunction

  // One clock: compare at the falling edge, advance the model at the rising
  // edge, then leave inputs free to change 1 time unit later.
  task automatic step();
    @(negedge clk);
    if (!rst_n) begin
      ma_t = 0; mb_t = 0; ma_c = 0; mb_c = 0;
    end
    chk("a_ctl", pa, exp_out(4, 6, 2, ma_t, rst_n, en, in_valid, out_ready));
    chk("b_ctl", pb, exp_out(1, 1, 0, mb_t, rst_n, en, in_valid, out_ready));
    chk("a_cnt", cnt_a, ma_c);
    chk("b_cnt", cnt_b, mb_c);
    if (hp_a) acc_q.push_back(cyc);
    @(posedge clk);
    if (rst_n && ma_t == 13 && out_ready) ma_c = ma_c + 16'd1;
    if (rst_n && mb_t == 3 && out_ready)  mb_c = mb_c + 16'd1;
    ma_t = next_t(4, 6, 2, ma_t, rst_n, en, in_valid, out_ready);
    mb_t = next_t(1, 1, 0, mb_t, rst_n, en, in_valid, out_ready);
    cyc++;
    #1;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    #3;
    chk("rst_a", pa, 14'd0);
    chk("rst_b", pb, 14'd0);
    chk("rst_cnt", cnt_a, 16'd0);
    repeat (2) step();
    rst_n = 1'b1;

    // Single sample, out_ready high throughout.
    in_valid = 1'b1; step(); in_valid = 1'b0;
    repeat (15) step();
    chk("one_cnt_a", cnt_a, 16'd1);
    chk("one_cnt_b", cnt_b, 16'd1);

    // Output stalled for 5 cycles in OUT.
    in_valid = 1'b1; step(); in_valid = 1'b0;
    repeat (12) step();
    out_ready = 1'b0; repeat (5) step();
    out_ready = 1'b1; repeat (2) step();
    chk("stall_cnt", cnt_a, 16'd2);

    // in_valid held high: three accepts exactly 14 cycles apart.
    acc_q.delete();
    in_valid = 1'b1; repeat (42) step();
    in_valid = 1'b0; step();
    chk("b2b_n", acc_q.size(), 3);
    if (acc_q.size() == 3) begin
      chk("b2b_gap0", acc_q[1] - acc_q[0], 14);
      chk("b2b_gap1", acc_q[2] - acc_q[1], 14);
    end
    chk("b2b_cnt", cnt_a, 16'd5);

    // Reset asserted at cycle 7 of a sample.
    in_valid = 1'b1; step(); in_valid = 1'b0;
    repeat (6) step();
    rst_n = 1'b0; #1;
    chk("mid_rst_a", pa, 14'd0);
    chk("mid_rst_cnt", cnt_a, 16'd0);
    step();
    rst_n = 1'b1; #1;
    chk("rel_ready", ir_a, 1'b1);

    // en dropped one cycle after accept, in_valid kept high.
    in_valid = 1'b1; step();
    en = 1'b0; repeat (10) step();
    chk("en_drop_b", cnt_b, 16'd1);
    en = 1'b1; in_valid = 1'b0; repeat (10) step();

    // Random traffic with occasional reset pulses.
    for (int i = 0; i < 500; i++) begin
      en        = ($urandom_range(0, 9) != 0);
      in_valid  = ($urandom_range(0, 2) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      rst_n     = ($urandom_range(0, 149) != 0);
      step();
    end
    rst_n = 1'b1;
    repeat (3) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
